// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register index and data word, plus register file geometry.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NUM_RD = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic     wr_en;
    reg_idx_t wr_addr;
    word_t    wr_data;
  } wr_req_t;
endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two read ports and one write port between the datapath and reg_file.
interface reg_file_if;
  import cpu_pkg::*;

  reg_idx_t rd_addr_1;
  reg_idx_t rd_addr_2;
  word_t    rd_data_1;
  word_t    rd_data_2;
  logic     wr_en;
  reg_idx_t wr_addr;
  word_t    wr_data;

  modport master (
    output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data,
    input  rd_data_1, rd_data_2
  );

  modport slave (
    input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data,
    output rd_data_1, rd_data_2
  );
endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: zero check, write bypass and 32:1 mux.
module reg_file_rd_port
  import cpu_pkg::*;
(
  input  reg_idx_t                     i_rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_regs,
  input  logic                         i_wr_en,
  input  reg_idx_t                     i_wr_addr,
  input  word_t                        i_wr_data,
  input  logic                         i_rst_n,
  output word_t                        o_rd_data
);
  logic  w_zero;
  logic  w_hit;
  word_t w_mux;

  // Bypass compare runs alongside the mux; only the final select sits on the mux path.
  assign w_zero = (i_rd_addr == REG_ZERO);
  assign w_hit  = i_rst_n & i_wr_en & (i_wr_addr == i_rd_addr);
  assign w_mux  = i_regs[i_rd_addr];

  always_comb begin
    o_rd_data = w_mux;
    if (w_hit)  o_rd_data = i_wr_data;
    if (w_zero) o_rd_data = '0;
  end
endmodule

// File: rtl/reg_file.sv
// 2R1W register file, x0 hardwired to zero, write-first bypass on both read ports.
module reg_file
  import cpu_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  logic [DEPTH-1:1][DATA_W-1:0]  r_regs;
  logic [DEPTH-1:0][DATA_W-1:0]  w_regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (bus.wr_en) begin
      for (int i = 1; i < DEPTH; i++)
        if (bus.wr_addr == reg_idx_t'(i)) r_regs[i] <= bus.wr_data;
    end
  end

  // Entry 0 has no storage; a constant zero slot keeps the mux a clean power of two.
  assign w_regs    = {r_regs, {DATA_W{1'b0}}};
  assign w_rd_addr = {bus.rd_addr_2, bus.rd_addr_1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port u_port (
      .i_rd_addr (w_rd_addr[p]),
      .i_regs    (w_regs),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_rst_n   (rst_n),
      .o_rd_data (w_rd_data[p])
    );
  end

  assign bus.rd_data_1 = w_rd_data[0];
  assign bus.rd_data_2 = w_rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table, corner sequences, random vs. array model.
module tb_reg_file;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  word_t mem [DEPTH];

  reg_file_if u_if ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     wr_en;
    reg_idx_t wa;
    word_t    wd;
    reg_idx_t ra1;
    reg_idx_t ra2;
    word_t    e1;
    word_t    e2;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic we, input reg_idx_t wa, input word_t wd,
                       input reg_idx_t ra1, input reg_idx_t ra2);
    u_if.wr_en     = we;
    u_if.wr_addr   = wa;
    u_if.wr_data   = wd;
    u_if.rd_addr_1 = ra1;
    u_if.rd_addr_2 = ra2;
  endtask

  // Reference read: spec rules applied directly to the model array.
  function automatic word_t ref_rd(input reg_idx_t a);
    if (a == 0) return '0;
    if (rst_n && u_if.wr_en && u_if.wr_addr == a) return u_if.wr_data;
    if (!rst_n) return '0;
    return mem[a];
  endfunction

  function automatic word_t pat(input int i);
    return (i == 0) ? 32'h0 : 32'hA5A5_0000 + word_t'(i);
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    foreach (mem[i]) mem[i] = '0;

    // Reset: reads are zero everywhere, writes during reset are ignored.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1'b1, reg_idx_t'(i), 32'hFFFF_0000 | word_t'(i), reg_idx_t'(i), reg_idx_t'(DEPTH-1-i));
      #2;
      chk("rst_rd1", u_if.rd_data_1, 32'h0);
      chk("rst_rd2", u_if.rd_data_2, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 5'd1, 5'd31);
    #2;
    chk("rst_after_wr1", u_if.rd_data_1, 32'h0);
    chk("rst_after_wr2", u_if.rd_data_2, 32'h0);
    rst_n = 1'b1;

    // Vector table: write sweep with bypass, readback, same-address reads, x0 writes.
    for (int i = 1; i < DEPTH; i++)
      vecs.push_back('{1'b1, reg_idx_t'(i), pat(i), reg_idx_t'(i), reg_idx_t'(i-1), pat(i), pat(i-1)});
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{1'b0, '0, '0, reg_idx_t'(i), reg_idx_t'(DEPTH-1-i), pat(i), pat(DEPTH-1-i)});
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{1'b0, '0, '0, reg_idx_t'(i), reg_idx_t'(i), pat(i), pat(i)});
    vecs.push_back('{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, pat(5)});
    vecs.push_back('{1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd9, 32'h1234_5678, 32'h1234_5678});
    vecs.push_back('{1'b0, 5'd9, 32'hCAFE_0000, 5'd9, 5'd10, 32'h1234_5678, pat(10)});

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].wr_en, vecs[k].wa, vecs[k].wd, vecs[k].ra1, vecs[k].ra2);
      #2;
      chk($sformatf("vec%0d_rd1", k), u_if.rd_data_1, vecs[k].e1);
      chk($sformatf("vec%0d_rd2", k), u_if.rd_data_2, vecs[k].e2);
    end

    // Bypass: reg 7 old value, overwrite while reading it.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd8);
    #2;
    chk("byp_pre_rd1", u_if.rd_data_1, 32'h2222_2222);
    chk("byp_pre_rd2", u_if.rd_data_2, pat(8));
    @(posedge clk);
    #1;
    u_if.wr_en = 1'b0;
    #1;
    chk("byp_post_rd1", u_if.rd_data_1, 32'h2222_2222);
    chk("byp_post_rd2", u_if.rd_data_2, pat(8));

    // Mid-operation reset between edges.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, reg_idx_t'(i), 32'hDEAD_BEEF, 5'd0, 5'd0);
    end
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 5'd1, 5'd4);
    #1;
    chk("mid_pre_rd1", u_if.rd_data_1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd1", u_if.rd_data_1, 32'h0);
    chk("mid_rst_rd2", u_if.rd_data_2, 32'h0);
    u_if.rd_addr_1 = 5'd2;
    u_if.rd_addr_2 = 5'd3;
    #1;
    chk("mid_rst_rd2a", u_if.rd_data_1, 32'h0);
    chk("mid_rst_rd3a", u_if.rd_data_2, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h0000_0042, 5'd1, 5'd2);
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 5'd3, 5'd1);
    #1;
    chk("mid_wr3", u_if.rd_data_1, 32'h0000_0042);
    chk("mid_r1", u_if.rd_data_2, 32'h0);
    u_if.rd_addr_1 = 5'd2;
    u_if.rd_addr_2 = 5'd4;
    #1;
    chk("mid_r2", u_if.rd_data_1, 32'h0);
    chk("mid_r4", u_if.rd_data_2, 32'h0);
    u_if.rd_addr_1 = 5'd7;
    #1;
    chk("mid_r7", u_if.rd_data_1, 32'h0);

    // Random traffic against the array model, starting from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      reg_idx_t wa, ra1, ra2;
      @(negedge clk);
      wa  = reg_idx_t'($urandom_range(0, DEPTH-1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : reg_idx_t'($urandom_range(0, DEPTH-1));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : reg_idx_t'($urandom_range(0, DEPTH-1));
      drive(logic'($urandom_range(0, 1)), wa, word_t'($urandom), ra1, ra2);
      #2;
      chk("rnd_rd1", u_if.rd_data_1, ref_rd(ra1));
      chk("rnd_rd2", u_if.rd_data_2, ref_rd(ra2));
      @(posedge clk);
      if (u_if.wr_en && u_if.wr_addr != 0) mem[u_if.wr_addr] = u_if.wr_data;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
